// File: rtl/depacketizer_if.sv
// depacketizer_if
//   Groups the router-side flit/credit channel and the node-side word
//   stream of the depacketizer into one bundle.
//   channel         : {link_ctrl, flit valid, vc, head, data}, MSB first
//   flow_ctrl       : {credit valid, credit vc}
//   data_valid_out  : output word valid
//   data_ready_in   : node accepts the word
//   data_out        : flit data of the presented word
//   src_address_out : source address of the current packet
//   head_out        : presented word is a head flit
//   tail_out        : presented word is the last flit of its packet
//   vc_out          : VC of the presented word
// Modports: slave = depacketizer, master = router/node side driving it.
interface depacketizer_if #(
  parameter int num_vcs           = 4,
  parameter int flit_data_width   = 64,
  parameter int router_addr_width = 4,
  parameter int enable_link_pm    = 1
);
  localparam int vc_idx_width    = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int channel_width   = enable_link_pm + 1 + vc_idx_width + 1 + flit_data_width;
  localparam int flow_ctrl_width = 1 + vc_idx_width;

  logic [channel_width-1:0]     channel;
  logic [flow_ctrl_width-1:0]   flow_ctrl;
  logic                         data_valid_out;
  logic                         data_ready_in;
  logic [flit_data_width-1:0]   data_out;
  logic [router_addr_width-1:0] src_address_out;
  logic                         head_out;
  logic                         tail_out;
  logic [vc_idx_width-1:0]      vc_out;

  modport master (
    output channel, data_ready_in,
    input  flow_ctrl, data_valid_out, data_out, src_address_out,
           head_out, tail_out, vc_out
  );

  modport slave (
    input  channel, data_ready_in,
    output flow_ctrl, data_valid_out, data_out, src_address_out,
           head_out, tail_out, vc_out
  );
endinterface

// File: rtl/depacketizer.sv
// depacketizer
//   Receive endpoint for a router LOCAL output port. Flits are buffered in
//   one FIFO per VC, each VC's packet framing is checked, and whole packets
//   are handed to the node one at a time as a valid/ready word stream. Each
//   word accepted by the node returns one credit on flow_ctrl.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : depacketizer_if.slave (flit channel, credits, word stream)
//   error : sticky framing/overflow error, cleared only by reset
module depacketizer #(
  parameter int buffer_size        = 32,
  parameter int num_vcs            = 4,
  parameter int flit_data_width    = 64,
  parameter int router_addr_width  = 4,
  parameter int min_payload_length = 1,
  parameter int max_payload_length = 4,
  parameter int enable_link_pm     = 1
) (
  input  logic           clk,
  input  logic           reset,
  depacketizer_if.slave  bus,
  output logic           error
);

  localparam int VCW     = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int DW      = flit_data_width;
  localparam int AW      = router_addr_width;
  localparam int DEPTH   = buffer_size / num_vcs;
  localparam int PTRW    = $clog2(DEPTH);
  localparam int PLRANGE = max_payload_length - min_payload_length + 1;
  localparam int PLW     = (PLRANGE > 1) ? $clog2(PLRANGE) : 1;
  // Wide enough for any length a code field can express, not just legal ones.
  localparam int CNTW    = $clog2(min_payload_length + (1 << PLW));

  typedef enum logic { RX_IDLE, RX_BODY }     rx_state_e;
  typedef enum logic { OUT_IDLE, OUT_LOCKED } out_state_e;

  function automatic logic [CNTW-1:0] payload_len(input logic [DW-1:0] d);
    logic [PLW-1:0] code;
    code = d[2*AW +: PLW];
    if (PLRANGE > 1) return CNTW'(min_payload_length) + CNTW'(code);
    else             return CNTW'(min_payload_length);
  endfunction

  // ---------------- channel decode ----------------
  logic           in_valid;
  logic           in_head;
  logic [VCW-1:0] in_vc;
  logic [DW-1:0]  in_data;

  assign in_data  = bus.channel[DW-1:0];
  assign in_head  = bus.channel[DW];
  assign in_vc    = bus.channel[DW+1 +: VCW];
  assign in_valid = bus.channel[DW+1+VCW];

  generate
    if (enable_link_pm > 0) begin : g_link
      // Link power management is not handled by this endpoint.
      logic unused_link_ctrl;
      assign unused_link_ctrl = ^bus.channel[DW+2+VCW +: enable_link_pm];
    end
  endgenerate

  // ---------------- state ----------------
  logic [DW:0]     mem_q     [num_vcs][DEPTH];   // {head, data}
  logic [PTRW-1:0] wr_ptr_q  [num_vcs];
  logic [PTRW-1:0] wr_ptr_d  [num_vcs];
  logic [PTRW-1:0] rd_ptr_q  [num_vcs];
  logic [PTRW-1:0] rd_ptr_d  [num_vcs];
  logic [PTRW:0]   cnt_q     [num_vcs];
  logic [PTRW:0]   cnt_d     [num_vcs];
  rx_state_e       rx_state_q[num_vcs];
  rx_state_e       rx_state_d[num_vcs];
  logic [CNTW-1:0] rx_cnt_q  [num_vcs];
  logic [CNTW-1:0] rx_cnt_d  [num_vcs];

  out_state_e      out_state_q, out_state_d;
  logic [VCW-1:0]  lock_vc_q,   lock_vc_d;
  logic [CNTW-1:0] out_cnt_q,   out_cnt_d;
  logic [VCW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [AW-1:0]   src_q,       src_d;
  logic [VCW:0]    flow_q,      flow_d;
  logic            err_q,       err_d;

  logic [num_vcs-1:0] empty, full, eligible, wr_hit, rd_hit;
  logic               wr_en, ovf, proto_err, pop;
  logic [CNTW-1:0]    in_len;

  logic               grant_found;
  logic [VCW-1:0]     grant_vc, cand, sel_vc;
  logic [DW:0]        head_entry;
  logic [CNTW-1:0]    head_len;
  logic               out_valid;

  // ---------------- receive: FIFO write and per-VC framing check ----------------
  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      empty[v] = (cnt_q[v] == '0);
      full[v]  = (cnt_q[v] == (PTRW+1)'(DEPTH));
    end
    // A full FIFO refuses the write even if it is popped this cycle.
    wr_en  = reset && in_valid && !full[in_vc];
    ovf    = reset && in_valid &&  full[in_vc];
    in_len = payload_len(in_data);

    proto_err = 1'b0;
    for (int v = 0; v < num_vcs; v++) begin
      rx_state_d[v] = rx_state_q[v];
      rx_cnt_d[v]   = rx_cnt_q[v];
      // The checker tracks every flit on the link, dropped ones included.
      if (reset && in_valid && in_vc == VCW'(v)) begin
        if (rx_state_q[v] == RX_IDLE) begin
          if (in_head) begin
            rx_cnt_d[v]   = in_len;
            rx_state_d[v] = (in_len != '0) ? RX_BODY : RX_IDLE;
          end else begin
            proto_err = 1'b1;
          end
        end else begin
          if (in_head) begin
            // Resynchronise on the unexpected head.
            proto_err     = 1'b1;
            rx_cnt_d[v]   = in_len;
            rx_state_d[v] = (in_len != '0) ? RX_BODY : RX_IDLE;
          end else begin
            rx_cnt_d[v] = rx_cnt_q[v] - CNTW'(1);
            if (rx_cnt_q[v] == CNTW'(1)) rx_state_d[v] = RX_IDLE;
          end
        end
      end
    end
    err_d = err_q | proto_err | ovf;
  end

  // ---------------- output selection ----------------
  always_comb begin
    for (int v = 0; v < num_vcs; v++)
      eligible[v] = !empty[v] && mem_q[v][rd_ptr_q[v]][DW];

    grant_found = 1'b0;
    grant_vc    = rr_ptr_q;
    for (int i = 0; i < num_vcs; i++) begin
      cand = VCW'((int'(rr_ptr_q) + i) % num_vcs);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_vc    = cand;
      end
    end

    sel_vc     = (out_state_q == OUT_LOCKED) ? lock_vc_q : grant_vc;
    head_entry = mem_q[sel_vc][rd_ptr_q[sel_vc]];
    head_len   = payload_len(head_entry[DW-1:0]);
    out_valid  = (out_state_q == OUT_LOCKED) ? !empty[lock_vc_q] : grant_found;
    pop        = out_valid && bus.data_ready_in;
  end

  assign bus.data_valid_out  = out_valid;
  assign bus.data_out        = out_valid ? head_entry[DW-1:0] : '0;
  assign bus.head_out        = out_valid && head_entry[DW];
  assign bus.tail_out        = out_valid && ((out_state_q == OUT_LOCKED) ? (out_cnt_q == '0)
                                                                         : (head_len == '0));
  assign bus.vc_out          = out_valid ? sel_vc : '0;
  assign bus.src_address_out = !out_valid ? '0 :
                               (out_state_q == OUT_LOCKED) ? src_q : head_entry[AW +: AW];
  assign bus.flow_ctrl       = flow_q;
  assign error               = err_q;

  // ---------------- next state: pointers, arbiter, credit ----------------
  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      wr_hit[v]   = wr_en && (in_vc == VCW'(v));
      rd_hit[v]   = pop && (sel_vc == VCW'(v));
      wr_ptr_d[v] = wr_hit[v] ? wr_ptr_q[v] + PTRW'(1) : wr_ptr_q[v];
      rd_ptr_d[v] = rd_hit[v] ? rd_ptr_q[v] + PTRW'(1) : rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v] + (PTRW+1)'(wr_hit[v]) - (PTRW+1)'(rd_hit[v]);
    end

    out_state_d = out_state_q;
    lock_vc_d   = lock_vc_q;
    out_cnt_d   = out_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    src_d       = src_q;
    if (pop) begin
      if (out_state_q == OUT_IDLE) begin
        rr_ptr_d  = VCW'((int'(grant_vc) + 1) % num_vcs);
        lock_vc_d = grant_vc;
        src_d     = head_entry[AW +: AW];
        if (head_len != '0) begin
          out_state_d = OUT_LOCKED;
          out_cnt_d   = head_len - CNTW'(1);
        end
      end else if (out_cnt_q == '0) begin
        out_state_d = OUT_IDLE;
      end else begin
        out_cnt_d = out_cnt_q - CNTW'(1);
      end
    end
    flow_d = pop ? {1'b1, sel_vc} : '0;
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < num_vcs; v++) begin
        wr_ptr_q[v]   <= '0;
        rd_ptr_q[v]   <= '0;
        cnt_q[v]      <= '0;
        rx_state_q[v] <= RX_IDLE;
        rx_cnt_q[v]   <= '0;
      end
      out_state_q <= OUT_IDLE;
      lock_vc_q   <= '0;
      out_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      flow_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int v = 0; v < num_vcs; v++) begin
        wr_ptr_q[v]   <= wr_ptr_d[v];
        rd_ptr_q[v]   <= rd_ptr_d[v];
        cnt_q[v]      <= cnt_d[v];
        rx_state_q[v] <= rx_state_d[v];
        rx_cnt_q[v]   <= rx_cnt_d[v];
      end
      out_state_q <= out_state_d;
      lock_vc_q   <= lock_vc_d;
      out_cnt_q   <= out_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      flow_q      <= flow_d;
      err_q       <= err_d;
    end
  end

  // ---------------- data registers ----------------
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[in_vc][wr_ptr_q[in_vc]] <= {in_head, in_data};
    src_q <= src_d;
  end

endmodule

// File: tb/tb_depacketizer.sv
// tb_depacketizer
//   Directed bench for depacketizer. Stimulus pushes the expected words onto
//   a scoreboard queue; a negedge monitor pops and compares every accepted
//   word and checks the credit returned one cycle after each transfer.
module tb_depacketizer;
  localparam int NV = 4, DW = 64, AW = 4, BS = 32, DEPTH = BS / NV;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic error;

  always #5 clk = ~clk;

  depacketizer_if #(.num_vcs(NV), .flit_data_width(DW), .router_addr_width(AW),
                    .enable_link_pm(1)) bus ();

  depacketizer #(.buffer_size(BS), .num_vcs(NV), .flit_data_width(DW),
                 .router_addr_width(AW), .min_payload_length(0),
                 .max_payload_length(4), .enable_link_pm(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .error(error));

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  src;
    logic        head;
    logic        tail;
    logic [1:0]  vc;
  } word_t;

  word_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cred_vc0 = 0;
  int    cred_total = 0;
  logic  mon_on = 1'b0;
  logic  chk_stable = 1'b0;
  logic  prev_xfer = 1'b0;
  logic [1:0]  prev_vc = '0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [3:0] dest, input logic [3:0] src,
                                      input logic [2:0] code, input logic [52:0] user);
    return {user, code, src, dest};
  endfunction

  function automatic word_t w(input logic [63:0] d, input logic [3:0] s, input logic h,
                              input logic t, input logic [1:0] v);
    word_t r;
    r.data = d; r.src = s; r.head = h; r.tail = t; r.vc = v;
    return r;
  endfunction

  task automatic send(input logic lk, input logic [1:0] vc, input logic head, input logic [63:0] d);
    bus.channel = {lk, 1'b1, vc, head, d};
    @(posedge clk); #1;
    bus.channel = '0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, 128'(sb.size()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: credit of the previous transfer, stall stability, word compare.
  always @(negedge clk) begin
    if (mon_on) begin
      word_t exp_w, act_w;
      logic [2:0] exp_flow;
      exp_flow = prev_xfer ? {1'b1, prev_vc} : 3'b000;
      chk("credit", 128'(bus.flow_ctrl), 128'(exp_flow));
      if (bus.flow_ctrl[2]) begin
        cred_total++;
        if (bus.flow_ctrl[1:0] == 2'd0) cred_vc0++;
      end
      if (chk_stable && prev_stall)
        chk("stall_stable", 128'({bus.data_valid_out, bus.data_out}), 128'({1'b1, prev_data}));
      prev_xfer = 1'b0;
      if (reset && bus.data_valid_out && bus.data_ready_in) begin
        act_w = w(bus.data_out, bus.src_address_out, bus.head_out, bus.tail_out, bus.vc_out);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", act_w);
        end else begin
          exp_w = sb.pop_front();
          chk("word", 128'(act_w), 128'(exp_w));
          prev_xfer = 1'b1;
          prev_vc   = exp_w.vc;
        end
      end
      prev_stall = reset && bus.data_valid_out && !bus.data_ready_in;
      prev_data  = bus.data_out;
    end
  end

  initial begin
    logic [63:0] h;
    int c0;

    // 1: reset held 3 cycles with valid flits on the channel
    bus.data_ready_in = 1'b1;
    bus.channel = {1'b0, 1'b1, 2'd0, 1'b1, hdr(4'd1, 4'd2, 3'd0, 53'h5)};
    @(posedge clk);
    mon_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_outputs", 128'({bus.data_valid_out, bus.flow_ctrl, error, bus.data_out,
          bus.src_address_out, bus.head_out, bus.tail_out, bus.vc_out}), 128'(0));
      @(posedge clk);
    end
    #1;
    reset = 1'b1;
    bus.channel = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 128'({bus.data_valid_out, bus.flow_ctrl, error, bus.data_out,
          bus.src_address_out, bus.head_out, bus.tail_out, bus.vc_out}), 128'(0));
    end
    @(posedge clk); #1;

    // 2: single-flit packet on VC2, src 3, link_ctrl bit set
    h = hdr(4'd5, 4'd3, 3'd0, 53'h1abc);
    sb.push_back(w(h, 4'd3, 1'b1, 1'b1, 2'd2));
    send(1'b1, 2'd2, 1'b1, h);
    wait_drain(20, "single_flit_drain");

    // 3: head + 3 payload on VC0 with toggling ready
    cred_vc0 = 0;
    chk_stable = 1'b1;
    h = hdr(4'd2, 4'd6, 3'd3, 53'h77);
    sb.push_back(w(h, 4'd6, 1'b1, 1'b0, 2'd0));
    sb.push_back(w(64'hA1, 4'd6, 1'b0, 1'b0, 2'd0));
    sb.push_back(w(64'hA2, 4'd6, 1'b0, 1'b0, 2'd0));
    sb.push_back(w(64'hA3, 4'd6, 1'b0, 1'b1, 2'd0));
    fork
      begin
        send(1'b0, 2'd0, 1'b1, h);
        send(1'b0, 2'd0, 1'b0, 64'hA1);
        send(1'b0, 2'd0, 1'b0, 64'hA2);
        send(1'b0, 2'd0, 1'b0, 64'hA3);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          bus.data_ready_in = (i % 2 == 0);
          @(posedge clk); #1;
        end
        bus.data_ready_in = 1'b1;
      end
    join
    wait_drain(30, "backpressure_drain");
    chk_stable = 1'b0;
    chk("credits_vc0", 128'(cred_vc0), 128'(4));

    // 4: VC1 and VC3 packets interleaved flit by flit
    sb.push_back(w(hdr(4'd0, 4'd1, 3'd2, 53'h11), 4'd1, 1'b1, 1'b0, 2'd1));
    sb.push_back(w(64'hB1, 4'd1, 1'b0, 1'b0, 2'd1));
    sb.push_back(w(64'hB2, 4'd1, 1'b0, 1'b1, 2'd1));
    sb.push_back(w(hdr(4'd0, 4'd7, 3'd2, 53'h33), 4'd7, 1'b1, 1'b0, 2'd3));
    sb.push_back(w(64'hC1, 4'd7, 1'b0, 1'b0, 2'd3));
    sb.push_back(w(64'hC2, 4'd7, 1'b0, 1'b1, 2'd3));
    send(1'b0, 2'd1, 1'b1, hdr(4'd0, 4'd1, 3'd2, 53'h11));
    send(1'b0, 2'd3, 1'b1, hdr(4'd0, 4'd7, 3'd2, 53'h33));
    send(1'b0, 2'd1, 1'b0, 64'hB1);
    send(1'b0, 2'd3, 1'b0, 64'hC1);
    send(1'b0, 2'd1, 1'b0, 64'hB2);
    send(1'b0, 2'd3, 1'b0, 64'hC2);
    wait_drain(40, "interleave_drain");

    // 4b: pointer now at VC0, so VC0 wins over the earlier-arriving VC2
    bus.data_ready_in = 1'b0;
    sb.push_back(w(hdr(4'd9, 4'd4, 3'd0, 53'h40), 4'd4, 1'b1, 1'b1, 2'd0));
    sb.push_back(w(hdr(4'd9, 4'd5, 3'd0, 53'h42), 4'd5, 1'b1, 1'b1, 2'd2));
    send(1'b0, 2'd2, 1'b1, hdr(4'd9, 4'd5, 3'd0, 53'h42));
    send(1'b0, 2'd0, 1'b1, hdr(4'd9, 4'd4, 3'd0, 53'h40));
    bus.data_ready_in = 1'b1;
    wait_drain(20, "round_robin_drain");

    // 5: overflow VC0 with DEPTH+1 single-flit packets
    bus.data_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(w(hdr(4'd1, 4'd8, 3'd0, 53'(i + 100)), 4'd8, 1'b1, 1'b1, 2'd0));
      send(1'b0, 2'd0, 1'b1, hdr(4'd1, 4'd8, 3'd0, 53'(i + 100)));
    end
    @(negedge clk);
    chk("no_error_when_full", 128'(error), 128'(0));
    send(1'b0, 2'd0, 1'b1, hdr(4'd1, 4'd8, 3'd0, 53'd999));
    @(negedge clk);
    chk("overflow_error", 128'(error), 128'(1));
    @(posedge clk); #1;
    bus.data_ready_in = 1'b1;
    wait_drain(40, "overflow_drain");
    @(negedge clk);
    chk("overflow_dropped", 128'(bus.data_valid_out), 128'(0));

    // 6: clear error with reset, then a framing error, then reset mid-packet
    @(posedge clk); #1;
    bus.data_ready_in = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("error_cleared", 128'(error), 128'(0));
    send(1'b0, 2'd1, 1'b0, 64'h1111);
    @(negedge clk);
    chk("proto_error", 128'(error), 128'(1));
    send(1'b0, 2'd2, 1'b1, hdr(4'd3, 4'd2, 3'd2, 53'h9));
    send(1'b0, 2'd2, 1'b0, 64'hD1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("error_sticky", 128'(error), 128'(1));
    end
    c0 = cred_total;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.data_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flushed", 128'({bus.data_valid_out, error}), 128'(0));
    end
    chk("no_reset_credits", 128'(cred_total), 128'(c0));
    @(posedge clk); #1;
    sb.push_back(w(hdr(4'd6, 4'd9, 3'd0, 53'h5a), 4'd9, 1'b1, 1'b1, 2'd1));
    send(1'b0, 2'd1, 1'b1, hdr(4'd6, 4'd9, 3'd0, 53'h5a));
    wait_drain(20, "post_flush_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
